// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// Comparator result encoding is one-hot: eq, guess>target, guess<target.
package sar_search_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TRY  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] CMP_EQ = 3'b001;
   localparam logic [2:0] CMP_GT = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b100;

endpackage

// File: rtl/sar_search.sv
// MSB-first binary search against an external combinational comparator.
// One trial bit per clock, early exit on equality, err on inconsistent answers.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       cmp,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int KW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] guess_q,  guess_d;
   logic [KW-1:0]    k_q,      k_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             found_q,  found_d;
   logic             err_q,    err_d;

   logic [WIDTH-1:0] bit_k_s;
   logic [WIDTH-1:0] bit_km1_s;
   logic [KW-1:0]    k_m1_s;

   assign k_m1_s    = k_q - KW'(1);
   assign bit_k_s   = ONE << k_q;
   assign bit_km1_s = ONE << k_m1_s;

   // Next-state and output computation for the search FSM.
   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      k_d      = k_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      found_d  = found_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               guess_d  = ONE << (WIDTH - 1);
               k_d      = KW'(WIDTH - 1);
               busy_d   = 1'b1;
               found_d  = 1'b0;
               err_d    = 1'b0;
               result_d = '0;
               state_d  = TRY;
            end else begin
               state_d  = IDLE;
            end
         end
         TRY: begin
            case (cmp)
               CMP_EQ: begin
                  result_d = guess_q;
                  found_d  = 1'b1;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
               CMP_GT: begin
                  if (k_q != '0) begin
                     guess_d = (guess_q & ~bit_k_s) | bit_km1_s;
                     k_d     = k_m1_s;
                  end else begin
                     // Target 0 is never probed; a gt on the last bit implies it.
                     result_d = guess_q & ~ONE;
                     found_d  = 1'b1;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                     state_d  = DONE;
                  end
               end
               CMP_LT: begin
                  if (k_q != '0) begin
                     guess_d = guess_q | bit_km1_s;
                     k_d     = k_m1_s;
                  end else begin
                     result_d = guess_q;
                     err_d    = 1'b1;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                     state_d  = DONE;
                  end
               end
               default: begin
                  result_d = guess_q;
                  err_d    = 1'b1;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
            endcase
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         guess_q  <= '0;
         k_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         k_q      <= k_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end

   assign guess  = guess_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign found  = found_q;
   assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural 4-bit magnitude comparator
// as responder (a=guess, b=target) and an override path for corrupt answers.
module tb_sar_search;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] cmp;
   logic [3:0] guess;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic       found;
   logic       err;

   logic [3:0] target;
   logic       force_en;
   logic [2:0] force_val;
   logic [2:0] cmp_model;

   int n_cmp;
   int n_bad;

   sar_search #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .cmp    (cmp),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result),
      .found  (found),
      .err    (err)
   );

   always_comb begin
      if (guess == target)     cmp_model = 3'b001;
      else if (guess > target) cmp_model = 3'b010;
      else                     cmp_model = 3'b100;
   end
   assign cmp = force_en ? force_val : cmp_model;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Run one search; returns once done has pulsed and the block is back in IDLE.
   task automatic search(input string tag, input logic [3:0] tgt, input logic [3:0] exp_res,
                         input logic exp_found, input logic exp_err, input int exp_n,
                         input logic hold_start);
      int n;
      target = tgt;
      start  = 1'b1;
      @(posedge clk); #1;
      start = hold_start;
      chk({tag, "_busy"}, busy, 1);
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_found"}, found, exp_found);
      chk({tag, "_err"}, err, exp_err);
      if (exp_n > 0) chk({tag, "_n"}, n, exp_n);
      else           chk({tag, "_n_le4"}, (n >= 1 && n <= 4), 1);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_done_once"}, done, 0);
      chk({tag, "_result_held"}, result, exp_res);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      target    = 4'd0;
      force_en  = 1'b0;
      force_val = 3'b000;
      #3;
      chk("rst_out", {guess, busy, done, result, found, err}, 0);
      #7 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_hold", {busy, done}, 0);

      search("t1000", 4'b1000, 4'b1000, 1'b1, 1'b0, 1, 1'b0);
      search("t0000", 4'b0000, 4'b0000, 1'b1, 1'b0, 4, 1'b0);
      search("t0110", 4'b0110, 4'b0110, 1'b1, 1'b0, 3, 1'b0);
      search("t1111_hold", 4'b1111, 4'b1111, 1'b1, 1'b0, 4, 1'b1);

      for (int t = 0; t < 16; t++) begin
         search("sweep", 4'(t), 4'(t), 1'b1, 1'b0, 0, 1'b0);
      end

      // Corrupt answer in the second TRY cycle: guess is 0100 there for target 0110.
      target = 4'b0110;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("bad_guess2", guess, 4'b0100);
      force_en = 1'b1;
      @(posedge clk); #1;
      force_en = 1'b0;
      chk("bad_done", done, 1);
      chk("bad_err", err, 1);
      chk("bad_found", found, 0);
      chk("bad_result", result, 4'b0100);
      @(posedge clk); #1;
      chk("bad_done_once", done, 0);
      chk("bad_err_held", err, 1);

      // Reset in mid-search: outputs clear at once and no done pulse follows.
      target = 4'b0101;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_guess", guess, 4'b0110);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", {guess, busy, done, result, found, err}, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mid_rst_nodone", done, 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", {busy, done}, 0);
      search("t0101", 4'b0101, 4'b0101, 1'b1, 1'b0, 4, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
